lcrc_32_stream: RTL



---
 rtl/lcrc_pkg.sv | 32 +++
 rtl/lcrc_32_next.sv | 27 ++
 rtl/lcrc_32_stream.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lcrc_pkg.sv
// LCRC-32 constants, FSM state type and the reflected byte-update helper.
// Shared by the streaming engine and its combinational update block.
package lcrc_pkg;

    localparam logic [31:0] LCRC_POLY     = 32'h04C1_1DB7;
    localparam logic [31:0] LCRC_POLY_REF = 32'hEDB8_8320;
    localparam logic [31:0] LCRC_SEED     = 32'hFFFF_FFFF;
    localparam logic [31:0] LCRC_RESIDUE  = 32'hDEBB_20E3;

    localparam int MODE_GEN   = 0;
    localparam int MODE_CHECK = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_TAIL = 2'd2
    } state_e;

    // Bit 0 of each byte enters first, so the register shifts right.
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] r;
        r = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ LCRC_POLY_REF) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/lcrc_32_next.sv
// Combinational LCRC-32 update over the first nbytes_i bytes of a beat.
// Byte 0 of the beat is folded in first.
module lcrc_32_next
    import lcrc_pkg::*;
#(
    parameter int N  = 4,
    parameter int KW = 3
) (
    input  logic [31:0]    crc_i,
    input  logic [8*N-1:0] data_i,
    input  logic [KW-1:0]  nbytes_i,
    output logic [31:0]    crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int k = 0; k < N; k++) begin
            if (KW'(k) < nbytes_i) begin
                c = crc32_byte(c, data_i[8*k +: 8]);
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/lcrc_32_stream.sv
// Streaming LCRC-32 engine: GEN appends the LCRC to each packet,
// CHECK forwards the packet and reports the residue test at end of packet.
module lcrc_32_stream
    import lcrc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MODE   = MODE_GEN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_sop,
    input  logic                            in_eop,
    input  logic [$clog2(DATA_W/8)-1:0]     in_bcnt,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_sop,
    output logic                            out_eop,
    output logic [$clog2(DATA_W/8)-1:0]     out_bcnt,
    output logic                            crc_valid,
    output logic [31:0]                     crc_value,
    output logic                            crc_ok,
    output logic                            proto_err
);

    localparam int N  = DATA_W / 8;
    localparam int BW = $clog2(N);
    localparam int KW = BW + 1;

    state_e            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       tail_q, tail_d;
    logic [2:0]        tailn_q, tailn_d;
    logic [31:0]       lcrc_q, lcrc_d;
    logic              last_q, last_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic              osop_q, osop_d;
    logic              oeop_q, oeop_d;
    logic [BW-1:0]     obcnt_q, obcnt_d;
    logic              cv_q, cv_d;
    logic [31:0]       cval_q, cval_d;
    logic              cok_q, cok_d;
    logic              perr_q, perr_d;

    logic [KW-1:0]     kv;
    logic [31:0]       crc_base;
    logic [31:0]       crc_nx;
    logic [31:0]       fin;
    logic [31:0]       sh;
    logic              acc, ld, fire_out, in_pkt, gen_eop;
    int                k, tot;

    assign in_ready = (!ov_q || out_ready) && (state_q != ST_TAIL);
    assign kv       = (in_eop && in_bcnt != '0) ? {1'b0, in_bcnt} : KW'(N);
    assign crc_base = in_sop ? LCRC_SEED : crc_q;

    lcrc_32_next #(
        .N  (N),
        .KW (KW)
    ) u_next (
        .crc_i    (crc_base),
        .data_i   (in_data),
        .nbytes_i (kv),
        .crc_o    (crc_nx)
    );

    always_comb begin
        fire_out = ov_q && out_ready;
        ld       = !ov_q || out_ready;
        acc      = in_valid && in_ready;
        in_pkt   = in_sop || (state_q == ST_PKT);
        gen_eop  = (MODE == MODE_GEN) && in_pkt && in_eop;
        k        = int'(kv);
        fin      = ~crc_nx;
        tot      = (in_sop ? 0 : int'(cnt_q)) + k;
        sh       = '0;
        state_d  = state_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        tail_d   = tail_q;
        tailn_d  = tailn_q;
        lcrc_d   = lcrc_q;
        last_d   = last_q;
        ov_d     = ov_q;
        od_d     = od_q;
        osop_d   = osop_q;
        oeop_d   = oeop_q;
        obcnt_d  = obcnt_q;
        cv_d     = 1'b0;
        cval_d   = cval_q;
        cok_d    = cok_q;
        perr_d   = 1'b0;
        if (fire_out) begin
            ov_d   = 1'b0;
            last_d = 1'b0;
        end
        if (MODE == MODE_GEN && fire_out && last_q) begin
            cv_d   = 1'b1;
            cval_d = lcrc_q;
        end
        if (state_q == ST_TAIL) begin
            if (ld) begin
                ov_d    = 1'b1;
                osop_d  = 1'b0;
                oeop_d  = 1'b1;
                obcnt_d = BW'(int'(tailn_q) % N);
                od_d    = '0;
                for (int j = 0; j < 4; j++) begin
                    if (j < int'(tailn_q)) od_d[8*j +: 8] = tail_q[8*j +: 8];
                end
                last_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (acc) begin
            ov_d    = 1'b1;
            osop_d  = in_sop;
            oeop_d  = in_eop;
            obcnt_d = in_eop ? in_bcnt : '0;
            last_d  = 1'b0;
            // LCRC bytes land right after the last valid data byte.
            for (int j = 0; j < N; j++) begin
                if (j < k) begin
                    od_d[8*j +: 8] = in_data[8*j +: 8];
                end else if (gen_eop && j < k + 4) begin
                    sh             = fin >> (8 * (j - k));
                    od_d[8*j +: 8] = sh[7:0];
                end else begin
                    od_d[8*j +: 8] = 8'h00;
                end
            end
            if (in_sop && state_q == ST_PKT) perr_d = 1'b1;
            if (in_pkt && !in_eop) begin
                crc_d   = crc_nx;
                cnt_d   = (tot >= 4) ? 3'd4 : 3'(tot);
                state_d = ST_PKT;
            end else if (in_pkt) begin
                crc_d   = LCRC_SEED;
                cnt_d   = '0;
                state_d = ST_IDLE;
                if (MODE == MODE_CHECK) begin
                    cv_d   = 1'b1;
                    cval_d = crc_nx;
                    cok_d  = (crc_nx == LCRC_RESIDUE) && (tot >= 4);
                end else begin
                    lcrc_d = fin;
                    if (k + 4 <= N) begin
                        obcnt_d = BW'((k + 4) % N);
                        last_d  = 1'b1;
                    end else begin
                        oeop_d  = 1'b0;
                        obcnt_d = '0;
                        tail_d  = fin >> (8 * (N - k));
                        tailn_d = 3'(k + 4 - N);
                        state_d = ST_TAIL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            crc_q   <= LCRC_SEED;
            cnt_q   <= '0;
            tail_q  <= '0;
            tailn_q <= '0;
            lcrc_q  <= '0;
            last_q  <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
            obcnt_q <= '0;
            cv_q    <= 1'b0;
            cval_q  <= '0;
            cok_q   <= 1'b1;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            tail_q  <= tail_d;
            tailn_q <= tailn_d;
            lcrc_q  <= lcrc_d;
            last_q  <= last_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
            obcnt_q <= obcnt_d;
            cv_q    <= cv_d;
            cval_q  <= cval_d;
            cok_q   <= cok_d;
            perr_q  <= perr_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_sop   = osop_q;
    assign out_eop   = oeop_q;
    assign out_bcnt  = obcnt_q;
    assign crc_valid = cv_q;
    assign crc_value = cval_q;
    assign crc_ok    = cok_q;
    assign proto_err = perr_q;

endmodule
